// File: rtl/wave_loader_if.sv
// Stream-in / RAM-write bundle for wave_loader: the slave modport is the loader,
// the master modport is the byte source and waveform RAM side.
interface wave_loader_if #(
  parameter int ADDR_WIDTH = 12
) ();
  // Handshake: a byte moves on a rising clk edge where s_valid_i and s_ready_o are
  // both high; the source holds s_data_i stable while s_valid_i is high and unaccepted.
  logic [7:0]            s_data_i;
  logic                  s_valid_i;
  logic                  s_ready_o;
  logic [7:0]            wave_data_o;
  logic [ADDR_WIDTH-1:0] wave_addr_o;
  logic                  wave_load_en_o;
  logic [1:0]            dbg_state;

  modport master (
    output s_data_i, s_valid_i,
    input  s_ready_o, wave_data_o, wave_addr_o, wave_load_en_o, dbg_state
  );

  modport slave (
    input  s_data_i, s_valid_i,
    output s_ready_o, wave_data_o, wave_addr_o, wave_load_en_o, dbg_state
  );
endinterface

// File: rtl/wave_loader.sv
// Byte-stream loader for the NCO waveform RAM: writes len bytes at addresses 0..len-1.
// Optional trailer checksum check enabled by defining WAVE_LOADER_CSUM_EN.
module wave_loader #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DEPTH          = 4096,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   load_len_i,
  wave_loader_if.slave          bus,
  output logic                  nco_hold_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            err_code_o
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CSUM = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         len_q, len_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         idle_q, idle_d;
  logic [7:0]            data_q, data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  load_en_q, load_en_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [1:0]            err_q, err_d;
  logic                  xfer;
`ifdef WAVE_LOADER_CSUM_EN
  logic [7:0]            sum_q, sum_d;
`endif

  assign xfer = ready_q & bus.s_valid_i;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    idle_d    = idle_q;
    data_d    = data_q;
    addr_d    = addr_q;
    err_d     = err_q;
    load_en_d = 1'b0;
    done_d    = 1'b0;
`ifdef WAVE_LOADER_CSUM_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (load_len_i != '0 && load_len_i <= CW'(DEPTH)) begin
            len_d   = load_len_i;
            cnt_d   = '0;
            err_d   = 2'd0;
            state_d = S_LOAD;
`ifdef WAVE_LOADER_CSUM_EN
            sum_d   = 8'd0;
`endif
          end else begin
            err_d = 2'd1;
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
          load_en_d = 1'b1;
          addr_d    = cnt_q[ADDR_WIDTH-1:0];
          data_d    = bus.s_data_i;
          cnt_d     = cnt_q + CW'(1);
          idle_d    = '0;
`ifdef WAVE_LOADER_CSUM_EN
          sum_d     = sum_q + bus.s_data_i;
`endif
          // Count is one bit wider than the address so len==DEPTH terminates cleanly.
          if (cnt_q + CW'(1) == len_q) begin
`ifdef WAVE_LOADER_CSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
            done_d  = 1'b1;
`endif
          end
        end else if (idle_q == IDLE_LAST) begin
          err_d   = 2'd2;
          state_d = S_IDLE;
        end else begin
          idle_d = idle_q + TW'(1);
        end
      end
`ifdef WAVE_LOADER_CSUM_EN
      S_CSUM: begin
        if (xfer) begin
          // Trailer byte closes the sum to zero; it is never written to RAM.
          if (8'(sum_q + bus.s_data_i) == 8'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            err_d   = 2'd3;
            state_d = S_IDLE;
          end
        end else if (idle_q == IDLE_LAST) begin
          err_d   = 2'd2;
          state_d = S_IDLE;
        end else begin
          idle_d = idle_q + TW'(1);
        end
      end
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) idle_d = '0;
    ready_d = (state_d == S_LOAD) || (state_d == S_CSUM);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      idle_q    <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      load_en_q <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 2'd0;
`ifdef WAVE_LOADER_CSUM_EN
      sum_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      load_en_q <= load_en_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef WAVE_LOADER_CSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign bus.s_ready_o      = ready_q;
  assign bus.wave_data_o    = data_q;
  assign bus.wave_addr_o    = addr_q;
  assign bus.wave_load_en_o = load_en_q;
  assign bus.dbg_state      = state_q;
  assign nco_hold_o         = busy_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign err_code_o         = err_q;

endmodule

// File: tb/tb_wave_loader.sv
// Randomised and directed bench for wave_loader, checked every cycle against a
// transaction-level reference model with a write scoreboard.
module tb_wave_loader;
  localparam int AW    = 12;
  localparam int DEPTH = 4096;
  localparam int TMO   = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [AW:0]   load_len_i = '0;
  logic          nco_hold, busy, done;
  logic [1:0]    err_code;

  wave_loader_if #(.ADDR_WIDTH(AW)) bus ();

  wave_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .load_len_i (load_len_i),
    .bus        (bus.slave),
    .nco_hold_o (nco_hold),
    .busy_o     (busy),
    .done_o     (done),
    .err_code_o (err_code)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [AW+7:0] exp_q[$];
  logic [7:0]    tb_ram [0:DEPTH-1];
  int wr_cnt = 0, done_cnt = 0, last_addr = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the load as a transaction: how many bytes remain, whether a trailer is owed,
  // and the idle run length; outputs are what must be visible after each clock.
  bit   m_active, m_loading, m_trailer, m_finishing;
  bit   m_we, m_done;
  int   m_len, m_count, m_idle, m_sum, m_addr, m_data;
  logic [1:0] m_err;

  always @(posedge clk) begin
    bit xfer;
    xfer   = (m_loading || m_trailer) && bus.s_valid_i;
    m_we   = 1'b0;
    m_done = 1'b0;
    if (rst) begin
      m_active = 0; m_loading = 0; m_trailer = 0; m_finishing = 0;
      m_len = 0; m_count = 0; m_idle = 0; m_sum = 0; m_addr = 0; m_data = 0; m_err = 0;
      exp_q.delete();
    end else if (!m_active) begin
      if (start_i) begin
        if (load_len_i >= 1 && load_len_i <= DEPTH) begin
          m_active = 1; m_loading = 1; m_len = int'(load_len_i);
          m_count = 0; m_idle = 0; m_sum = 0; m_err = 0;
        end else begin
          m_err = 1;
        end
      end
    end else if (m_finishing) begin
      m_active = 0; m_finishing = 0;
    end else if (xfer) begin
      m_idle = 0;
      if (m_loading) begin
        m_we = 1; m_addr = m_count; m_data = int'(bus.s_data_i);
        exp_q.push_back({m_count[AW-1:0], bus.s_data_i});
        m_sum = (m_sum + int'(bus.s_data_i)) % 256;
        m_count++;
        if (m_count == m_len) begin
          m_loading = 0;
`ifdef WAVE_LOADER_CSUM_EN
          m_trailer = 1;
`else
          m_finishing = 1; m_done = 1;
`endif
        end
      end else begin
        m_trailer = 0;
        if ((m_sum + int'(bus.s_data_i)) % 256 == 0) begin
          m_finishing = 1; m_done = 1;
        end else begin
          m_active = 0; m_err = 3;
        end
      end
    end else begin
      m_idle++;
      if (m_idle == TMO) begin
        m_active = 0; m_loading = 0; m_trailer = 0; m_err = 2;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    logic [AW+7:0] w;
    #1;
    check("s_ready", bus.s_ready_o, m_loading || m_trailer);
    check("busy", busy, m_active);
    check("nco_hold", nco_hold, m_active);
    check("done", done, m_done);
    check("err_code", err_code, m_err);
    check("load_en", bus.wave_load_en_o, m_we);
    check("wave_addr", bus.wave_addr_o, m_addr);
    check("wave_data", bus.wave_data_o, m_data);
    if (bus.wave_load_en_o === 1'b1) begin
      wr_cnt++;
      last_addr = int'(bus.wave_addr_o);
      tb_ram[bus.wave_addr_o] = bus.wave_data_o;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        w = exp_q.pop_front();
        check("write_entry", {bus.wave_addr_o, bus.wave_data_o}, w);
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    bus.s_valid_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input int len);
    start_i    = 1'b1;
    load_len_i = len[AW:0];
    @(negedge clk);
    start_i    = 1'b0;
  endtask

  // Leaves s_valid_i high so successive calls stream back-to-back.
  task automatic send_byte(input logic [7:0] d);
    int n;
    n = 0;
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = d;
    while (bus.s_ready_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("ready_wait_timeout", 0, 1);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0, d0;
    bus.s_valid_i = 1'b0;
    bus.s_data_i  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_s_ready", bus.s_ready_o, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_code, 0);
    rst = 1'b0;
    idle(2);

    // Four bytes back-to-back.
    w0 = wr_cnt; d0 = done_cnt;
    do_start(4);
    send_byte(8'd10); send_byte(8'd20); send_byte(8'd30); send_byte(8'd40);
    idle(4);
    check("len4_writes", wr_cnt - w0, 4);
    check("len4_ram0", tb_ram[0], 8'd10);
    check("len4_ram1", tb_ram[1], 8'd20);
    check("len4_ram2", tb_ram[2], 8'd30);
    check("len4_ram3", tb_ram[3], 8'd40);
    check("len4_last_addr", last_addr, 3);
    check("len4_done", done_cnt - d0, 1);

    // Full depth, one byte every other clock, data = low address byte.
    w0 = wr_cnt; d0 = done_cnt;
    do_start(DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(i[7:0]);
      idle(1);
    end
    idle(4);
    check("full_writes", wr_cnt - w0, DEPTH);
    check("full_last_addr", last_addr, DEPTH - 1);
    check("full_ram_4095", tb_ram[4095], 8'hFF);
    check("full_ram_256", tb_ram[256], 8'h00);
    check("full_ram_1234", tb_ram[1234], 8'hD2);
    check("full_done", done_cnt - d0, 1);

    // Illegal lengths, then start while busy.
    w0 = wr_cnt;
    do_start(0);
    idle(2);
    check("len0_err", err_code, 1);
    check("len0_ready", bus.s_ready_o, 0);
    do_start(DEPTH + 1);
    idle(2);
    check("len4097_err", err_code, 1);
    check("bad_len_writes", wr_cnt - w0, 0);
    w0 = wr_cnt; d0 = done_cnt;
    do_start(2);
    do_start(3);
    send_byte(8'hA5); send_byte(8'h5A);
    idle(4);
    check("busy_start_writes", wr_cnt - w0, 2);
    check("busy_start_done", done_cnt - d0, 1);
    check("busy_start_err", err_code, 0);

    // Timeout after three bytes.
    w0 = wr_cnt; d0 = done_cnt;
    do_start(8);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    idle(50);
    check("tmo_still_busy", busy, 1);
    idle(60);
    check("tmo_idle", busy, 0);
    check("tmo_err", err_code, 2);
    check("tmo_writes", wr_cnt - w0, 3);
    check("tmo_no_done", done_cnt - d0, 0);

    // Reset in the middle of a load.
    do_start(8);
    send_byte(8'h01); send_byte(8'h02);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_ready", bus.s_ready_o, 0);
    check("midrst_load_en", bus.wave_load_en_o, 0);
    check("midrst_addr", bus.wave_addr_o, 0);
    check("midrst_err", err_code, 0);
    rst = 1'b0;
    idle(2);
    w0 = wr_cnt; d0 = done_cnt;
    do_start(2);
    send_byte(8'h77); send_byte(8'h88);
    idle(4);
    check("postrst_writes", wr_cnt - w0, 2);
    check("postrst_done", done_cnt - d0, 1);

`ifdef WAVE_LOADER_CSUM_EN
    w0 = wr_cnt; d0 = done_cnt;
    do_start(3);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'hFA);
    idle(4);
    check("csum_ok_writes", wr_cnt - w0, 3);
    check("csum_ok_done", done_cnt - d0, 1);
    w0 = wr_cnt; d0 = done_cnt;
    do_start(3);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'hFB);
    idle(4);
    check("csum_bad_writes", wr_cnt - w0, 3);
    check("csum_bad_done", done_cnt - d0, 0);
    check("csum_bad_err", err_code, 3);
`endif

    // Random traffic: starts of mixed legality, bursty valid, rare resets.
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 9));
      start_i       = ($urandom_range(0, 19) == 0);
      load_len_i    = (r == 0) ? '0 : (r == 1) ? (AW+1)'(DEPTH + 1) : (AW+1)'($urandom_range(1, 16));
      bus.s_valid_i = ($urandom_range(0, 2) != 0);
      bus.s_data_i  = 8'($urandom_range(0, 255));
      rst           = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    start_i = 1'b0;
    rst     = 1'b0;
    idle(TMO + 20);
    check("final_idle", busy, 0);
    check("final_exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
